// File: rtl/inst_fetch.sv
// Byte-serial Y86 instruction fetcher: assembles variable-length
// instructions into a 48-bit bus under a valid/ready handshake.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr_o,
  output logic        mem_rd_o,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_ack_i,
  output logic [47:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic        inst_err_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    HALTED
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  len;
  logic [31:0] pc;
  logic        rd;

  function automatic logic [2:0] ilen(
    input logic [3:0] ic
  );
    logic [2:0] l;
    l = 3'd1;
    unique case (1'b1)
      (ic inside {4'h2, 4'h6, 4'hA, 4'hB}): l = 3'd2;
      (ic inside {4'h7, 4'h8}):             l = 3'd5;
      (ic inside {4'h3, 4'h4, 4'h5}):       l = 3'd6;
      default:                              l = 3'd1;
    endcase
    return l;
  endfunction

  logic       ack;
  logic [2:0] blen;
  logic       last;
  logic       halt;

  assign ack  = rd && mem_ack_i && (state == FETCH);
  assign blen = (cnt == 3'd0) ? ilen(mem_data_i[7:4]) : len;
  assign last = (cnt == blen - 3'd1);
  assign halt = (inst_o[47:44] == 4'h0) || inst_err_o;

  assign mem_addr_o   = pc + {29'd0, cnt};
  assign mem_rd_o     = rd;
  assign pc_o         = pc;
  assign inst_valid_o = (state == HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      cnt        <= 3'd0;
      len        <= 3'd1;
      pc         <= RESET_PC;
      rd         <= 1'b0;
      inst_o     <= 48'd0;
      inst_err_o <= 1'b0;
    end else if (redirect_i) begin
      // wins over any ack or transfer in the same cycle
      state <= FETCH;
      cnt   <= 3'd0;
      pc    <= redirect_pc_i;
      rd    <= 1'b1;
    end else begin
      unique case (state)
        FETCH: begin
          rd <= 1'b1;
          if (ack) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd0) begin
              inst_o     <= {mem_data_i, 40'd0};
              len        <= blen;
              inst_err_o <= (mem_data_i[7:4] >= 4'hC);
            end else if (len == 3'd5) begin
              inst_o[{cnt, 3'b000} +: 8] <= mem_data_i;
            end else if (cnt == 3'd1) begin
              inst_o[39:32] <= mem_data_i;
            end else begin
              inst_o[{cnt - 3'd2, 3'b000} +: 8] <= mem_data_i;
            end
            if (last) begin
              state <= HOLD;
              rd    <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (inst_ready_i) begin
            pc  <= pc + {29'd0, len};
            cnt <= 3'd0;
            if (halt) begin
              state <= HALTED;
              rd    <= 1'b0;
            end else begin
              state <= FETCH;
              rd    <= 1'b1;
            end
          end
        end
        HALTED: rd <= 1'b0;
        default: begin
          state <= FETCH;
          rd    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: vector table plus redirect,
// backpressure and async reset sequences.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o;
  logic [7:0]  mem_data_i;
  logic        mem_ack_i;
  logic [47:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        inst_err_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr_o   (mem_addr_o),
    .mem_rd_o     (mem_rd_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_err_o   (inst_err_o),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk = ~clk;

  // byte memory with programmable wait states
  logic [7:0] mem [0:4095];
  int wait_cfg = 0;
  int wcnt = 0;
  int xfers = 0;

  always_comb mem_data_i = mem[mem_addr_o[11:0]];
  assign mem_ack_i = mem_rd_o && (wcnt >= wait_cfg);

  always @(posedge clk) begin
    if (!mem_rd_o || mem_ack_i || redirect_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (inst_valid_o && inst_ready_i) xfers <= xfers + 1;
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!inst_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!inst_valid_o) begin
      checks++;
      errs++;
      $display("FAIL valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic redir(input logic [31:0] a);
    redirect_i    = 1'b1;
    redirect_pc_i = a;
    @(negedge clk);
    redirect_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [47:0] raw;
    int          len;
    int          waits;
    int          hold;
    logic [47:0] inst;
    logic        err;
    logic        halts;
    logic [31:0] nxt;
  } vec_t;

  vec_t v [10];

  initial begin
    int n;
    int x0;
    logic [31:0] a;
    logic [47:0] snap;

    v[0] = '{32'h100, 48'h30F078563412, 6, 0, 0,
             48'h30F012345678, 1'b0, 1'b0, 32'h106};
    v[1] = '{32'h200, 48'h700002000000, 5, 0, 0,
             48'h700000020000, 1'b0, 1'b0, 32'h205};
    v[2] = '{32'h300, 48'h600100000000, 2, 1, 3,
             48'h600100000000, 1'b0, 1'b0, 32'h302};
    v[3] = '{32'h310, 48'h804433221100, 5, 0, 0,
             48'h801122334400, 1'b0, 1'b0, 32'h315};
    v[4] = '{32'h320, 48'h900000000000, 1, 2, 1,
             48'h900000000000, 1'b0, 1'b0, 32'h321};
    v[5] = '{32'h330, 48'h5012EFBEADDE, 6, 0, 1,
             48'h5012DEADBEEF, 1'b0, 1'b0, 32'h336};
    v[6] = '{32'h340, 48'hA04F00000000, 2, 0, 0,
             48'hA04F00000000, 1'b0, 1'b0, 32'h342};
    v[7] = '{32'hFFFFFFFE, 48'h30F301020304, 6, 0, 0,
             48'h30F304030201, 1'b0, 1'b0, 32'h4};
    v[8] = '{32'h350, 48'h000000000000, 1, 0, 0,
             48'h000000000000, 1'b0, 1'b1, 32'h351};
    v[9] = '{32'h360, 48'hE00000000000, 1, 0, 0,
             48'hE00000000000, 1'b1, 1'b1, 32'h361};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h10;
    rst           = 1'b0;
    inst_ready_i  = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;

    // reset state, then NOP at address 0
    repeat (2) @(negedge clk);
    chk("rst_addr",  mem_addr_o,   0);
    chk("rst_rd",    mem_rd_o,     0);
    chk("rst_inst",  inst_o,       0);
    chk("rst_pc",    pc_o,         0);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_err",   inst_err_o,   0);
    rst = 1'b1;
    @(negedge clk);
    chk("nop_rd",   mem_rd_o,   1);
    chk("nop_addr", mem_addr_o, 0);
    @(negedge clk);
    chk("nop_valid", inst_valid_o, 1);
    chk("nop_inst",  inst_o, 48'h100000000000);
    chk("nop_pc",    pc_o, 0);
    inst_ready_i = 1'b1;
    @(negedge clk);
    inst_ready_i = 1'b0;
    chk("nop_next", mem_addr_o, 1);
    chk("nop_nrd",  mem_rd_o,   1);

    // vector table
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < v[k].len; i++) begin
        a = v[k].pc + i;
        mem[a[11:0]] = v[k].raw[47 - 8 * i -: 8];
      end
      wait_cfg = v[k].waits;
      redir(v[k].pc);
      chk($sformatf("v%0d_addr", k), mem_addr_o, v[k].pc);
      chk($sformatf("v%0d_rd", k), mem_rd_o, 1);
      wait_valid(n);
      chk($sformatf("v%0d_lat", k), n,
          v[k].len * (v[k].waits + 1));
      chk($sformatf("v%0d_inst", k), inst_o, v[k].inst);
      chk($sformatf("v%0d_pc", k), pc_o, v[k].pc);
      chk($sformatf("v%0d_err", k), inst_err_o, v[k].err);
      chk($sformatf("v%0d_hold_rd", k), mem_rd_o, 0);
      snap = inst_o;
      for (int h = 0; h < v[k].hold; h++) begin
        @(negedge clk);
        chk($sformatf("v%0d_bp_valid", k), inst_valid_o, 1);
        chk($sformatf("v%0d_bp_inst", k), inst_o, snap);
        chk($sformatf("v%0d_bp_rd", k), mem_rd_o, 0);
      end
      x0 = xfers;
      inst_ready_i = 1'b1;
      @(negedge clk);
      inst_ready_i = 1'b0;
      chk($sformatf("v%0d_xfer", k), xfers - x0, 1);
      chk($sformatf("v%0d_valid_off", k), inst_valid_o, 0);
      if (v[k].halts) begin
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_halt_rd", k), mem_rd_o, 0);
        chk($sformatf("v%0d_halt_v", k), inst_valid_o, 0);
      end else begin
        chk($sformatf("v%0d_next", k), mem_addr_o, v[k].nxt);
        chk($sformatf("v%0d_nrd", k), mem_rd_o, 1);
      end
    end

    // redirect after 2 of 6 bytes acked
    mem[12'h400] = 8'h10;
    wait_cfg = 0;
    redir(32'h100);
    repeat (2) @(negedge clk);
    chk("mid_addr", mem_addr_o, 32'h102);
    redir(32'h400);
    chk("mid_new", mem_addr_o, 32'h400);
    chk("mid_valid", inst_valid_o, 0);
    wait_valid(n);
    chk("mid_lat", n, 1);
    chk("mid_pc", pc_o, 32'h400);
    chk("mid_inst", inst_o, 48'h100000000000);

    // redirect coinciding with a transfer
    redir(32'h300);
    wait_valid(n);
    chk("rx_inst", inst_o, 48'h600100000000);
    x0 = xfers;
    inst_ready_i  = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h500;
    @(negedge clk);
    inst_ready_i = 1'b0;
    redirect_i   = 1'b0;
    chk("rx_xfer", xfers - x0, 1);
    chk("rx_addr", mem_addr_o, 32'h500);
    chk("rx_valid", inst_valid_o, 0);

    // async reset in the middle of a 5-byte fetch
    redir(32'h200);
    repeat (2) @(negedge clk);
    chk("ar_pre", mem_addr_o, 32'h202);
    #2 rst = 1'b0;
    #1;
    chk("ar_addr",  mem_addr_o,   0);
    chk("ar_rd",    mem_rd_o,     0);
    chk("ar_inst",  inst_o,       0);
    chk("ar_pc",    pc_o,         0);
    chk("ar_valid", inst_valid_o, 0);
    chk("ar_err",   inst_err_o,   0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
